// File: rtl/sign_narrow.sv
// Signed narrowing unit: range-checks wide signed words, emits narrow encoding + fit flag via a 2-entry FIFO.
// Define SIGN_NARROW_SAT_EN to saturate out-of-range words; default build truncates them.
module sign_narrow #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 4,
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_fit,
  input  logic             clr_count,
  output logic [CNT_W-1:0] ovf_count
);

  typedef struct packed {
    logic [OUT_W-1:0] data;
    logic             fit;
  } entry_t;

  entry_t     q [2];
  logic       wr_ptr, rd_ptr;
  logic [1:0] occ;
  logic       push, pop;
  logic       fit;
  entry_t     new_e;

  // Representable iff every bit from the MSB down to the narrow sign bit agrees.
  assign fit = (&in_data[IN_W-1:OUT_W-1]) | ~(|in_data[IN_W-1:OUT_W-1]);

  always_comb begin
    new_e.fit = fit;
`ifdef SIGN_NARROW_SAT_EN
    if (fit)
      new_e.data = in_data[OUT_W-1:0];
    else if (in_data[IN_W-1])
      new_e.data = {1'b1, {(OUT_W-1){1'b0}}};
    else
      new_e.data = {1'b0, {(OUT_W-1){1'b1}}};
`else
    new_e.data = in_data[OUT_W-1:0];
`endif
  end

  assign in_ready  = (occ < 2'd2);
  assign out_valid = (occ != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_data  = q[rd_ptr].data;
  assign out_fit   = q[rd_ptr].fit;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      occ    <= 2'd0;
      q[0]   <= '0;
      q[1]   <= '0;
    end else begin
      if (push) begin
        q[wr_ptr] <= new_e;
        wr_ptr    <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

  // Clear beats a same-cycle increment; saturates instead of wrapping.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      ovf_count <= '0;
    else if (clr_count)
      ovf_count <= '0;
    else if (push && !fit && (ovf_count != {CNT_W{1'b1}}))
      ovf_count <= ovf_count + 1'b1;
  end

endmodule

// File: doc/sign_narrow.md
# sign_narrow

Registered signed-narrowing unit, the inverse of the immediate sign extender. It accepts wide signed words over a valid/ready handshake and checks whether each one is representable in the narrow field. It emits the narrow two's-complement encoding plus a fit flag through a 2-entry output queue. It sits on the instruction-assembly path, packing computed offsets back into immediate fields, and counts out-of-range events.

## Interface
- IN_W, 16, width of the signed input word
- OUT_W, 4, width of the signed narrow output field (2 ≤ OUT_W < IN_W)
- CNT_W, 8, width of the overflow event counter
- clock  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- in_valid  input  1  input word offered
- in_ready  output  1  unit can accept a word this cycle
- in_data  input  IN_W  signed input word
- out_valid  output  1  head entry valid
- out_ready  input  1  consumer takes head entry this cycle
- out_data  output  OUT_W  narrowed signed value of head entry
- out_fit  output  1  head entry was exactly representable in OUT_W bits
- clr_count  input  1  synchronous clear of ovf_count
- ovf_count  output  CNT_W  saturating count of accepted non-fitting words

One clock; reset is asynchronous and active-low.

## Operation
- Fit rule: in_data[IN_W-1:OUT_W-1] all zeros or all ones → fit=1, else fit=0.
- Fitting word: out_data = in_data[OUT_W-1:0].
- Non-fitting word: encoding per Configuration; fit=0 always stored.
- Queue: 2-entry FIFO of {data, fit}, occupancy 0..2.
- Push on in_valid && in_ready. Pop on out_valid && out_ready.
- in_ready = (occupancy < 2), combinational from occupancy only, never from out_ready.
- out_valid = (occupancy > 0). out_data/out_fit show the head entry and hold stable while out_valid && !out_ready.
- Simultaneous push+pop at occupancy 1: occupancy stays 1, new word becomes head next cycle. At occupancy 2 no push is possible. At 0 no pop is possible.
- Wrap-around: read/write pointers are 1 bit each and toggle. Entry order is strictly FIFO.
- ovf_count increments by 1 on each push with fit=0. It saturates at all-ones and does not wrap.
- clr_count=1 forces ovf_count to 0 next edge. Clear wins over a simultaneous increment, so the result is 0.
- in_data is ignored when no push occurs.

## Timing
- Reset (async assert, any time including mid-transfer): occupancy 0, pointers 0, out_valid=0, out_data=0, out_fit=0, ovf_count=0, in_ready=1. Queued entries are discarded.
- Reset release: first push is possible on the first rising edge with reset_n=1.
- Latency: word pushed at edge N gives out_valid=1 with its data after edge N. There is no combinational input→output bypass.
- Throughput: 1 word/cycle sustained when out_ready held high.
- Backpressure: two pushes with out_ready=0 fill the queue and in_ready drops after the second edge. One pop re-raises in_ready after that edge.
- ovf_count updates on the same edge as the push of the offending word.

## Configuration
- SIGN_NARROW_SAT_EN defined: non-fitting words saturate. A positive word (in_data[IN_W-1]=0) becomes 0 followed by OUT_W-1 ones, e.g. 4'h7. A negative word becomes 1 followed by OUT_W-1 zeros, e.g. 4'h8.
- SIGN_NARROW_SAT_EN undefined: non-fitting words are truncated, out_data = in_data[OUT_W-1:0].
- Fit detection, out_fit and ovf_count behave identically in both builds.

## Test plan
- Reset mid-stream with 2 entries queued → out_valid=0, out_data=4'h0, ovf_count=0, in_ready=1 immediately, without waiting for a clock edge.
- Push 16'h0007, then 16'hFFF8, out_ready=1 → outputs 4'h7 fit=1, then 4'h8 fit=1, each one cycle after its push; ovf_count stays 0.
- Push 16'h0008, then 16'h8000: SAT build → 4'h7 fit=0, then 4'h8 fit=0. Non-SAT build → 4'h8 fit=0, then 4'h0 fit=0. ovf_count=2 in both builds.
- out_ready=0; push 16'h0001, 16'h0002, then offer 16'h0003 → in_ready=0 after the second push, third word not accepted, head holds 4'h1. Raise out_ready → 4'h1, 4'h2, 4'h3 emerge in order.
- Occupancy 1 with simultaneous push of 16'hFFFF and pop → occupancy stays 1; next head is 4'hF fit=1.
- Push 300 non-fitting words with CNT_W=8 → ovf_count saturates at 8'hFF. Assert clr_count on the same cycle as another non-fitting push → ovf_count=0.
